// File: rtl/or1200_alarm_ctrl.sv
// Alarm aggregator for privilege-checker results. Per-channel persistence filter,
// sticky alarm with cause capture, and a 4-phase clear handshake.
module or1200_alarm_ctrl #(
    parameter int unsigned NUM_CHK = 8,
    parameter int unsigned PERSIST = 2,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned EVT_W   = 8,
    parameter bit          LOCK    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CHK-1:0] chk_ok,
    input  logic [NUM_CHK-1:0] chk_en,
    input  logic               clear_req,
    output logic               clear_ack,
    output logic               alarm,
    output logic [NUM_CHK-1:0] cause,
    output logic [NUM_CHK-1:0] first_cause,
    output logic [EVT_W-1:0]   alarm_cnt,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        TRIPPED  = 2'd1,
        CLEARING = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PERSIST_MAX = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] PERSIST_M1  = CNT_W'(PERSIST - 1);

    state_t                          state_q, state_d;
    logic                            alarm_q, alarm_d;
    logic                            clear_ack_q, clear_ack_d;
    logic [NUM_CHK-1:0]              cause_q, cause_d;
    logic [NUM_CHK-1:0]              first_cause_q, first_cause_d;
    logic [EVT_W-1:0]                alarm_cnt_q, alarm_cnt_d;
    logic [NUM_CHK-1:0][CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic [NUM_CHK-1:0] fail;
    logic [NUM_CHK-1:0] trip;
    logic               flush;
    logic               clear_ok;

    always_comb begin
        fail     = chk_en & ~chk_ok;
        clear_ok = clear_req && !LOCK;
        trip     = '0;
        for (int unsigned i = 0; i < NUM_CHK; i++) begin
            trip[i] = fail[i] && (fail_cnt_q[i] == PERSIST_M1);
        end
        // Checks are ignored while clearing, including PERSIST=1 where an idle counter matches.
        if (state_q == CLEARING) begin
            trip = '0;
        end

        state_d       = state_q;
        alarm_d       = alarm_q;
        cause_d       = cause_q;
        first_cause_d = first_cause_q;
        alarm_cnt_d   = alarm_cnt_q;
        clear_ack_d   = 1'b0;
        flush         = 1'b0;

        case (state_q)
            ARMED: begin
                if (|trip) begin
                    state_d       = TRIPPED;
                    alarm_d       = 1'b1;
                    first_cause_d = trip;
                    cause_d       = cause_q | trip;
                    if (alarm_cnt_q != '1) begin
                        alarm_cnt_d = alarm_cnt_q + EVT_W'(1);
                    end
                end else if (clear_ok) begin
                    state_d       = CLEARING;
                    flush         = 1'b1;
                    clear_ack_d   = 1'b1;
                    alarm_d       = 1'b0;
                    cause_d       = '0;
                    first_cause_d = '0;
                end
            end
            TRIPPED: begin
                alarm_d = 1'b1;
                cause_d = cause_q | trip;
                if (clear_ok) begin
                    state_d       = CLEARING;
                    flush         = 1'b1;
                    clear_ack_d   = 1'b1;
                    alarm_d       = 1'b0;
                    cause_d       = '0;
                    first_cause_d = '0;
                end
            end
            CLEARING: begin
                flush = 1'b1;
                if (!clear_req) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = TRIPPED;
                alarm_d = 1'b1;
                cause_d = cause_q | trip;
            end
        endcase

        for (int unsigned i = 0; i < NUM_CHK; i++) begin
            if (flush || !fail[i]) begin
                fail_cnt_d[i] = '0;
            end else if (fail_cnt_q[i] == PERSIST_MAX) begin
                fail_cnt_d[i] = fail_cnt_q[i];
            end else begin
                fail_cnt_d[i] = fail_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARMED;
            alarm_q       <= 1'b0;
            clear_ack_q   <= 1'b0;
            cause_q       <= '0;
            first_cause_q <= '0;
            alarm_cnt_q   <= '0;
            fail_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            alarm_q       <= alarm_d;
            clear_ack_q   <= clear_ack_d;
            cause_q       <= cause_d;
            first_cause_q <= first_cause_d;
            alarm_cnt_q   <= alarm_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
        end
    end

    assign clear_ack   = clear_ack_q;
    assign alarm       = alarm_q;
    assign cause       = cause_q;
    assign first_cause = first_cause_q;
    assign alarm_cnt   = alarm_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_or1200_alarm_ctrl.sv
// Directed bench for or1200_alarm_ctrl: one default instance (PERSIST=2, LOCK=0)
// and one PERSIST=1, LOCK=1 instance sharing the same stimulus.
module tb_or1200_alarm_ctrl;

    localparam logic [1:0] S_A = 2'd0;
    localparam logic [1:0] S_T = 2'd1;
    localparam logic [1:0] S_C = 2'd2;

    typedef struct packed {
        logic       alarm;
        logic [7:0] cause;
        logic [7:0] first;
        logic [7:0] cnt;
        logic [1:0] st;
        logic       ack;
    } out_t;

    typedef struct {
        logic [7:0] ok;
        logic [7:0] en;
        logic       clr;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] chk_ok = 8'hFF;
    logic [7:0] chk_en = 8'hFF;
    logic       clear_req = 1'b0;

    logic       ack_m, alarm_m, ack_l, alarm_l;
    logic [7:0] cause_m, first_m, cnt_m, cause_l, first_l, cnt_l;
    logic [1:0] st_m, st_l;
    out_t       got_m, got_l;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    or1200_alarm_ctrl #(.NUM_CHK(8), .PERSIST(2), .CNT_W(4), .EVT_W(8), .LOCK(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .chk_ok(chk_ok), .chk_en(chk_en), .clear_req(clear_req),
        .clear_ack(ack_m), .alarm(alarm_m), .cause(cause_m), .first_cause(first_m),
        .alarm_cnt(cnt_m), .state_o(st_m)
    );

    or1200_alarm_ctrl #(.NUM_CHK(8), .PERSIST(1), .CNT_W(4), .EVT_W(8), .LOCK(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .chk_ok(chk_ok), .chk_en(chk_en), .clear_req(clear_req),
        .clear_ack(ack_l), .alarm(alarm_l), .cause(cause_l), .first_cause(first_l),
        .alarm_cnt(cnt_l), .state_o(st_l)
    );

    assign got_m = {alarm_m, cause_m, first_m, cnt_m, st_m, ack_m};
    assign got_l = {alarm_l, cause_l, first_l, cnt_l, st_l, ack_l};

    function automatic out_t mk(input logic a, input logic [7:0] c, input logic [7:0] f,
                                input logic [7:0] n, input logic [1:0] s, input logic k);
        out_t o;
        o.alarm = a; o.cause = c; o.first = f; o.cnt = n; o.st = s; o.ack = k;
        return o;
    endfunction

    task automatic add(input logic [7:0] ok, input logic [7:0] en, input logic clr, input out_t e);
        vec_t v;
        v.ok = ok; v.en = en; v.clr = clr; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got alarm=%0b cause=%h first=%h cnt=%h state=%0d ack=%0b, expected alarm=%0b cause=%h first=%h cnt=%h state=%0d ack=%0b",
                     name, got.alarm, got.cause, got.first, got.cnt, got.st, got.ack,
                     exp.alarm, exp.cause, exp.first, exp.cnt, exp.st, exp.ack);
        end
    endtask

    task automatic step(input logic [7:0] ok, input logic [7:0] en, input logic clr);
        @(negedge clk);
        chk_ok    = ok;
        chk_en    = en;
        clear_req = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Main-instance vectors, outputs expected after each edge.
        add(8'hF7, 8'hFF, 0, mk(0, 8'h00, 8'h00, 0, S_A, 0));
        add(8'hFF, 8'hFF, 0, mk(0, 8'h00, 8'h00, 0, S_A, 0));
        add(8'hD7, 8'hFF, 0, mk(0, 8'h00, 8'h00, 0, S_A, 0));
        add(8'hD7, 8'hFF, 0, mk(1, 8'h28, 8'h28, 1, S_T, 0));
        add(8'hFE, 8'hFF, 0, mk(1, 8'h28, 8'h28, 1, S_T, 0));
        add(8'hFE, 8'hFF, 0, mk(1, 8'h29, 8'h28, 1, S_T, 0));
        add(8'hFF, 8'hFF, 1, mk(0, 8'h00, 8'h00, 1, S_C, 1));
        for (int i = 0; i < 5; i++) add(8'hFF, 8'hFF, 1, mk(0, 8'h00, 8'h00, 1, S_C, 0));
        add(8'hFF, 8'hFF, 0, mk(0, 8'h00, 8'h00, 1, S_A, 0));
        for (int i = 0; i < 10; i++) add(8'hFB, 8'hFB, 0, mk(0, 8'h00, 8'h00, 1, S_A, 0));
        add(8'hFB, 8'hFF, 0, mk(0, 8'h00, 8'h00, 1, S_A, 0));
        add(8'hFB, 8'hFB, 0, mk(0, 8'h00, 8'h00, 1, S_A, 0));
        add(8'hFB, 8'hFF, 0, mk(0, 8'h00, 8'h00, 1, S_A, 0));
        add(8'hFB, 8'hFF, 0, mk(1, 8'h04, 8'h04, 2, S_T, 0));
        add(8'hFF, 8'hFF, 1, mk(0, 8'h00, 8'h00, 2, S_C, 1));
        add(8'hFF, 8'hFF, 0, mk(0, 8'h00, 8'h00, 2, S_A, 0));
        add(8'h7F, 8'hFF, 0, mk(0, 8'h00, 8'h00, 2, S_A, 0));
        add(8'h7F, 8'hFF, 1, mk(1, 8'h80, 8'h80, 3, S_T, 0));
        add(8'hFF, 8'hFF, 1, mk(0, 8'h00, 8'h00, 3, S_C, 1));
        add(8'hFF, 8'hFF, 0, mk(0, 8'h00, 8'h00, 3, S_A, 0));
        add(8'hFF, 8'hFF, 1, mk(0, 8'h00, 8'h00, 3, S_C, 1));
        add(8'hFE, 8'hFF, 1, mk(0, 8'h00, 8'h00, 3, S_C, 0));
        add(8'hFE, 8'hFF, 0, mk(0, 8'h00, 8'h00, 3, S_A, 0));
        add(8'hFE, 8'hFF, 0, mk(0, 8'h00, 8'h00, 3, S_A, 0));
        add(8'hFE, 8'hFF, 0, mk(1, 8'h01, 8'h01, 4, S_T, 0));
        add(8'hFF, 8'hFF, 1, mk(0, 8'h00, 8'h00, 4, S_C, 1));
        add(8'hFF, 8'hFF, 0, mk(0, 8'h00, 8'h00, 4, S_A, 0));

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        check("reset_main", got_m, mk(0, 0, 0, 0, S_A, 0));
        check("reset_lock", got_l, mk(0, 0, 0, 0, S_A, 0));
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].ok, tbl[i].en, tbl[i].clr);
            check($sformatf("vec%0d", i), got_m, tbl[i].exp);
        end

        // Asynchronous reset while TRIPPED, checked between clock edges.
        step(8'hFE, 8'hFF, 0);
        step(8'hFE, 8'hFF, 0);
        check("pre_async_rst", got_m, mk(1, 8'h01, 8'h01, 5, S_T, 0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_main", got_m, mk(0, 0, 0, 0, S_A, 0));
        chk_ok = 8'hFF; clear_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Trip/clear cycles until the event counter saturates.
        for (int i = 1; i <= 260; i++) begin
            step(8'hFE, 8'hFF, 0);
            step(8'hFE, 8'hFF, 0);
            step(8'hFF, 8'hFF, 1);
            step(8'hFF, 8'hFF, 0);
            check($sformatf("sat%0d", i), got_m,
                  mk(0, 0, 0, (i > 255) ? 8'hFF : 8'(i), S_A, 0));
        end

        // LOCK=1, PERSIST=1 instance.
        @(negedge clk);
        rst_n = 1'b0; chk_ok = 8'hFF; clear_req = 1'b0;
        @(negedge clk);
        check("reset_lock2", got_l, mk(0, 0, 0, 0, S_A, 0));
        rst_n = 1'b1;
        step(8'hFF, 8'hFF, 1);
        check("lock_armed_clr", got_l, mk(0, 0, 0, 0, S_A, 0));
        step(8'hFE, 8'hFF, 1);
        check("lock_trip", got_l, mk(1, 8'h01, 8'h01, 1, S_T, 0));
        for (int i = 0; i < 4; i++) begin
            step(8'hFF, 8'hFF, 1);
            check($sformatf("lock_hold%0d", i), got_l, mk(1, 8'h01, 8'h01, 1, S_T, 0));
        end
        step(8'hFD, 8'hFF, 0);
        check("lock_cause_or", got_l, mk(1, 8'h03, 8'h01, 1, S_T, 0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_lock", got_l, mk(0, 0, 0, 0, S_A, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/or1200_alarm_ctrl.md
Name: or1200_alarm_ctrl

Overview:
- Parametrised, sequential successor to the privilege-checker alarm aggregator.
- Collects NUM_CHK assertion results from the CPU-level and top-level checkers and applies a per-channel enable mask.
- A failure must persist for PERSIST consecutive cycles before it trips a sticky alarm. The block records first and accumulated causes, counts trip events and releases the alarm only through a 4-phase clear handshake, which LOCK mode can disable.

Parameters:
- NUM_CHK, 8: number of check channels.
- PERSIST, 2: consecutive failing cycles needed to trip a channel. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of each per-channel persistence counter.
- EVT_W, 8: width of the trip-event counter.
- LOCK, 0: when 1, clear_req is ignored and the alarm holds until reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- chk_ok  in  NUM_CHK  per-channel assertion result; 1 = pass.
- chk_en  in  NUM_CHK  per-channel enable; 0 = channel ignored.
- clear_req  in  1  level clear request, 4-phase.
- clear_ack  out  1  single-cycle clear acknowledge.
- alarm  out  1  sticky registered alarm.
- cause  out  NUM_CHK  sticky OR of all channels tripped since the last clear.
- first_cause  out  NUM_CHK  channels that tripped on the ARMED->TRIPPED edge.
- alarm_cnt  out  EVT_W  saturating count of ARMED->TRIPPED transitions.
- state_o  out  2  FSM state: 0 ARMED, 1 TRIPPED, 2 CLEARING.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ARMED.
  - All fail_cnt=0.
  - alarm=0, cause=0, first_cause=0, alarm_cnt=0, clear_ack=0.
- Channel fail condition: fail[i] = chk_en[i] & ~chk_ok[i], sampled each rising edge.
- Persistence counter fail_cnt[i]:
  - Clears to 0 on any non-fail cycle.
  - Otherwise increments, saturating at PERSIST.
- Trip condition: trip[i] = fail[i] & (fail_cnt[i] == PERSIST-1).
  - PERSIST=1: a single failing sample trips.
  - A channel already saturated at PERSIST does not re-trip until it has passed at least one cycle.
- Latency: alarm is registered and goes high on the same edge that samples the trip.
  - Example: PERSIST=2 with fail sampled at edges k and k+1 gives alarm=1 after edge k+1.
- FSM, state ARMED:
  - On any trip: go to TRIPPED; alarm<=1; first_cause<=trip; cause<=cause|trip; alarm_cnt+=1, saturating at all-ones.
  - Trip and clear_req in the same cycle: trip wins. clear_req is re-evaluated in TRIPPED on the next edge.
  - clear_req=1 with no trip (LOCK=0): go to CLEARING (counters flushed).
- FSM, state TRIPPED:
  - alarm stays 1.
  - Further trips OR into cause; first_cause and alarm_cnt are unchanged.
  - clear_req=1 and LOCK=0: go to CLEARING.
  - LOCK=1: remain in TRIPPED until reset.
- FSM, state CLEARING:
  - On entry edge: alarm<=0, cause<=0, first_cause<=0, all fail_cnt<=0; clear_ack=1 for exactly this first CLEARING cycle.
  - While in CLEARING, fail_cnt is held at 0 and checks are ignored.
  - Leave to ARMED on the first edge that samples clear_req=0.
  - A failure present on that exit edge begins counting on the following edge.
- clear_ack is a pulse; it never re-asserts while clear_req stays high.
- alarm_cnt is cleared only by reset, never by a clear.
- chk_en deasserted mid-count clears that channel's counter on the next edge. A partial count never survives a disable.
- Reset asserted mid-operation, in any state, forces the reset values immediately (asynchronous).
- state_o encoding 3 is illegal. The FSM recovers from it to TRIPPED with alarm=1 (fail-secure).

Test Plan:
- PERSIST=2, chk_en=8'hFF, chk_ok[3]=0 for 1 cycle then 1 -> alarm stays 0, cause=0, alarm_cnt=0.
- chk_ok[3]=0 and chk_ok[5]=0 for 2 cycles -> alarm=1 after the second edge; first_cause=8'h28, cause=8'h28, alarm_cnt=1. Then chk_ok[0]=0 for 2 cycles -> cause=8'h29, first_cause=8'h28, alarm_cnt=1.
- In TRIPPED, raise clear_req -> next edge: alarm=0, cause=0, clear_ack=1 for 1 cycle, state=CLEARING. Hold clear_req 5 cycles -> clear_ack stays 0. Drop clear_req -> ARMED, alarm_cnt still 1.
- chk_en[2]=0, chk_ok[2]=0 for 10 cycles -> no alarm. Set chk_en[2]=1 after 1 failing cycle and toggle chk_en off/on -> counter restarts; alarm only after 2 consecutive enabled fails.
- In ARMED, trip and clear_req in the same cycle -> alarm=1, state=TRIPPED. On the following edge: CLEARING, clear_ack=1.
- LOCK=1: trip, then clear_req for 4 cycles -> alarm stays 1, clear_ack never asserts. Pulse rst_n low mid-cycle -> all outputs 0 immediately. Also drive 255 trip/clear cycles with EVT_W=8 -> alarm_cnt saturates at 8'hFF.
